link_upstream_tx: RTL
=====================

# link_upstream_tx

Upstream (transmit) end of the core-to-IO source-synchronous link. The block accepts DATA_W-bit words from the core over a valid/ready handshake and serializes each word into FLIT_W-bit flits on io_data_o/io_valid_o. It gates transmission with a credit counter that is replenished by toggles on the token line returned from the downstream receiver. The downstream receiver's async FIFO depth sets CREDITS, and its token decimation sets TOKEN_DECIM.

## Interface
Parameters:
- DATA_W, 32: core word width; must be a multiple of FLIT_W.
- FLIT_W, 8: io flit width.
- CREDITS, 16: initial and maximum credits, in words; must equal the receiver FIFO depth.
- TOKEN_DECIM, 4: credits returned per token toggle; power of 2, ≤ CREDITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- core_data_i  in  DATA_W  word to send.
- core_valid_i  in  1  core_data_i valid.
- core_ready_o  out  1  word accepted when core_valid_i && core_ready_o.
- io_data_o  out  FLIT_W  current flit; registered.
- io_valid_o  out  1  flit valid; registered.
- io_token_i  in  1  token line from receiver; asynchronous; each edge (rise or fall) is one token.
- credit_count_o  out  $clog2(CREDITS+1)  current credit count.
- credit_err_o  out  1  sticky credit overflow flag (see Configuration).

## Operation
- BEATS = DATA_W/FLIT_W. Beat counter width: $clog2(BEATS), minimum 1.
- FSM states:
  - IDLE: no word in flight.
  - SEND: shifting out a word.
- core_ready_o is combinational: (credits != 0) && (state == IDLE || (state == SEND && beat == BEATS-1)).
- Accept:
  - Load core_data_i into the shift register.
  - Consume one credit.
  - Enter or stay in SEND with beat = 0.
- SEND, each cycle:
  - io_valid_o = 1; io_data_o = shift[FLIT_W-1:0], low flit first.
  - Shift right by FLIT_W; beat++.
- After beat BEATS-1:
  - If a new accept occurs in the same cycle, continue in SEND with no bubble.
  - Otherwise go to IDLE; io_valid_o = 0 and io_data_o holds its last value.
- Token path:
  - 2-flop synchronizer on io_token_i, then a previous-value register.
  - An edge is sync2 != prev.
  - Each edge adds TOKEN_DECIM credits.
- Credit arithmetic:
  - next = credits − consume + (edge ? TOKEN_DECIM : 0).
  - Simultaneous consume and edge yields a net of +TOKEN_DECIM−1.
  - The result saturates at CREDITS; overflow sets credit_err_o when enabled.
  - Credits never go below 0: consume requires credits != 0.
- Reset values:
  - io_valid_o = 0, io_data_o = 0.
  - credits = CREDITS, state = IDLE, beat = 0.
  - Sync flops and prev = 0.
  - credit_err_o = 0.
- Reset mid-word: the partial word is dropped and io_valid_o = 0 the cycle after reset. The receiver is reset together with the transmitter, so its token line is low at reset.

## Timing
- Word accepted at edge N: flit k drives io_data_o with io_valid_o = 1 in cycle N+1+k, for k = 0..BEATS-1.
- Sustained throughput: one word per BEATS cycles while credits > 0.
- Credit decrement is visible on credit_count_o the cycle after accept.
- io_token_i edge sampled at edge T: sync1 captures it at T, sync2 at T+1, and credit_count_o increases after edge T+2. Worst case is 3 cycles of latency.
- When credits reach 0, core_ready_o drops in the same cycle. It rises the cycle after credits become nonzero.
- core_valid_i may deassert without acceptance; core_data_i is sampled only on accept.

## Configuration
- Macro LINK_UPSTREAM_TX_CREDIT_ERR_EN.
- Defined: credit_err_o sets on any update whose unsaturated result exceeds CREDITS, and clears only on rst.
- Undefined: credit_err_o is tied to 0 and the overflow detection logic is omitted. Saturation behaviour is unchanged.

## Test plan
- Single word: reset, accept 0xDDCCBBAA → io_data_o = AA, BB, CC, DD in cycles N+1..N+4 with io_valid_o = 1, then 0; credit_count_o goes 16→15.
- Back-to-back: core_valid_i held high with 3 words → 12 consecutive io_valid_o cycles, no gaps, flits in order; credits = 13.
- Credit exhaustion: send 16 words with no tokens → core_ready_o = 0 after the 16th accept and io_valid_o idle; toggle io_token_i once → credits = 4 three cycles later and core_ready_o = 1.
- Simultaneous event: token edge reaches the counter in the same cycle as an accept with credits = 2 → credits = 5.
- Overflow: with the macro defined and credits = 16, toggle io_token_i → credits stay 16 and credit_err_o = 1 until rst; with the macro undefined, credit_err_o stays 0.
- Reset mid-word: assert rst after flit 1 of a word → io_valid_o = 0 the next cycle, credits = 16, remaining flits never appear.

Source files
------------

// File: rtl/link_upstream_tx.sv
// Upstream link transmitter: serializes DATA_W words into FLIT_W flits, low flit first, gated by receiver credits.
// Latency: first flit registered one cycle after accept; back-to-back words stream with no bubble.
// Backpressure: core_ready_o drops while a word is mid-flight or credits are zero. Optional macro LINK_UPSTREAM_TX_CREDIT_ERR_EN enables sticky overflow flag.
module link_upstream_tx #(
    parameter int DATA_W      = 32,
    parameter int FLIT_W      = 8,
    parameter int CREDITS     = 16,
    parameter int TOKEN_DECIM = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            core_data_i,
    input  logic                         core_valid_i,
    output logic                         core_ready_o,
    output logic [FLIT_W-1:0]            io_data_o,
    output logic                         io_valid_o,
    input  logic                         io_token_i,
    output logic [$clog2(CREDITS+1)-1:0] credit_count_o,
    output logic                         credit_err_o
);
    localparam int BEATS = DATA_W / FLIT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(CREDITS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW:0]   MAX_SUM   = (CW+1)'(CREDITS);
    localparam logic [CW:0]   DECIM     = (CW+1)'(TOKEN_DECIM);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0]     beat;
    logic [CW-1:0]     credits;
    logic              last_beat;
    logic              accept;
    logic              sync1, sync2, prev;
    logic              token_edge;
    logic [CW:0]       sum;
    logic              overflow;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        last_beat    = 1'b0;
        core_ready_o = 1'b0;
        accept       = 1'b0;
        state_next   = state;
        last_beat    = (state == SEND) && (beat == LAST_BEAT);
        core_ready_o = (credits != '0) && ((state == IDLE) || last_beat);
        accept       = core_valid_i && core_ready_o;
        if (accept)         state_next = SEND;
        else if (last_beat) state_next = IDLE;
    end

    // Flit shown on io_data_o always corresponds to the current beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift      <= '0;
            beat       <= '0;
            io_data_o  <= '0;
            io_valid_o <= 1'b0;
        end else if (accept) begin
            io_data_o  <= core_data_i[FLIT_W-1:0];
            shift      <= core_data_i >> FLIT_W;
            beat       <= '0;
            io_valid_o <= 1'b1;
        end else if ((state == SEND) && !last_beat) begin
            io_data_o  <= shift[FLIT_W-1:0];
            shift      <= shift >> FLIT_W;
            beat       <= beat + 1'b1;
            io_valid_o <= 1'b1;
        end else begin
            io_valid_o <= 1'b0;
        end
    end

    // Token line is asynchronous; every level change after synchronization is one token.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= io_token_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        token_edge = (sync2 != prev);
        sum        = {1'b0, credits} - {{CW{1'b0}}, accept} + (token_edge ? DECIM : '0);
        overflow   = (sum > MAX_SUM);
    end

    always_ff @(posedge clk) begin
        if (rst)           credits <= CRED_MAX;
        else if (overflow) credits <= CRED_MAX;
        else               credits <= sum[CW-1:0];
    end

    assign credit_count_o = credits;

`ifdef LINK_UPSTREAM_TX_CREDIT_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst)           err_q <= 1'b0;
        else if (overflow) err_q <= 1'b1;
    end
    assign credit_err_o = err_q;
`else
    assign credit_err_o = 1'b0;
`endif

endmodule
